branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Fetch-stage branch predictor for the LC-3b pipeline: a direct-mapped branch target buffer with per-entry 2-bit saturating counters. It supplies the predicted next PC to fetch each cycle. This is the same address that travels down the pipeline and is checked against the resolved target by the MEM/WB-stage branch detection logic. It is trained by the resolved-branch update port from MEM/WB.

## Interface

Parameters:
- ENTRIES, 8: number of BTB entries; power of two, 2..64.
- IDX_W, $clog2(ENTRIES): index width; derived, do not override.

Ports (lc3b_word = 16 bits):
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- fetch_pc, input, 16: PC of the instruction currently in IF.
- predict_addr, output, 16: predicted next PC, combinational from fetch_pc and registered table state.
- predict_taken, output, 1: high when predict_addr comes from a BTB target.
- upd_valid, input, 1: resolved control-flow instruction present in MEM/WB this cycle.
- upd_pc, input, 16: PC of the resolved instruction.
- upd_taken, input, 1: resolved direction, 1 = taken.
- upd_target, input, 16: resolved target address.

## Operation

- Entry state: valid (1), tag (16-1-IDX_W bits), target (16), ctr (2).
- Index is pc[IDX_W:1]; tag is pc[15:IDX_W+1]. pc[0] is ignored (word aligned).
- Lookup:
  - hit = valid & tag match.
  - predict_taken = hit & ctr[1].
  - predict_addr = predict_taken ? target : fetch_pc + 16'h0002, computed modulo 2^16.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Update when upd_valid is high at a clock edge:
  - Hit, taken: ctr increments, saturating at 11. Target is overwritten with upd_target.
  - Hit, not taken: ctr decrements, saturating at 00. Target is unchanged.
  - Miss, taken: allocate or replace. Set valid=1, tag, target=upd_target, ctr=10.
  - Miss, not taken: no change.
- upd_valid low: table holds.
- No stall or flush inputs. The table is only written by the update port. Prediction is stateless with respect to the pipeline.

## Timing

- Lookup latency is 0 cycles; it is a combinational read of registered state.
- An update is visible to lookup on the cycle after the edge that wrote it.
- Update and lookup to the same index in the same cycle: lookup returns the pre-update contents. There is no bypass.
- Reset (asynchronous, takes effect at any point, including mid-update):
  - All valid bits clear, all ctr = 01, tag and target = 0.
  - Outputs during and after reset: predict_taken=0, predict_addr=fetch_pc+2.
  - An update presented in the same cycle that rst deasserts is ignored. The first write occurs at the first edge with rst low.
- Wrap-around: fetch_pc=16'hFFFE with no hit gives predict_addr=16'h0000.

## Configuration

- BP_PERF_CNT_EN defined: adds three ports.
  - Inputs: upd_mispredict (input, 1), driven by the branch detection flush.
  - Outputs: bp_update_count and bp_mispredict_count (output, 16 each).
  - Each counter increments on an edge where upd_valid is high; the mispredict counter additionally requires upd_mispredict high.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- BP_PERF_CNT_EN not defined: these ports and counters do not exist. Prediction behaviour is identical in both builds.

## Test plan

- Reset, fetch_pc=16'h1000: predict_addr=16'h1002, predict_taken=0. Assert rst mid-run after training and confirm the same values immediately, before any clock edge.
- Update pc=16'h1000, taken, target=16'h2000: the next cycle, fetch_pc=16'h1000 gives predict_addr=16'h2000, predict_taken=1.
- Counter walk on the trained entry:
  - One not-taken update: ctr 10→01, predict_addr=16'h1002.
  - Two taken updates: ctr 11, predicts 16'h2000.
  - Further taken updates hold ctr at 11.
  - Three not-taken updates reach 00 and hold.
- Aliasing with ENTRIES=8: after training 16'h1000, fetch_pc=16'h1010 (same index, different tag) gives 16'h1012.
  - Taken update at 16'h1010, target 16'h3000, replaces the entry.
  - 16'h1000 then misses and predicts 16'h1002.
- Same-cycle update and lookup at 16'h1000 (first taken allocation): that cycle predicts 16'h1002, the next cycle predicts the target. fetch_pc=16'hFFFE untrained gives 16'h0000.
- With BP_PERF_CNT_EN: 5 updates, 2 with upd_mispredict high, give counts 5 and 2. After forcing saturation, the count stays 16'hFFFF.

Source files
------------

// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Fetch-stage branch predictor for the LC-3b pipeline: a direct-mapped
//   branch target buffer with one 2-bit saturating counter per entry. It
//   provides the predicted next PC to fetch every cycle. The resolved-branch
//   update port from MEM/WB trains it.
//
// Ports
//   clk                 : clock, all state changes on the rising edge
//   rst                 : asynchronous active-high reset
//   fetch_pc[15:0]      : PC of the instruction in IF
//   predict_addr[15:0]  : predicted next PC (combinational lookup)
//   predict_taken       : predict_addr comes from a BTB target
//   upd_valid           : resolved control-flow instruction in MEM/WB
//   upd_pc[15:0]        : PC of the resolved instruction
//   upd_taken           : resolved direction (1 = taken)
//   upd_target[15:0]    : resolved target address
//
// Optional build macro BP_PERF_CNT_EN adds:
//   upd_mispredict            : input, flush from branch detection
//   bp_update_count[15:0]     : saturating count of updates
//   bp_mispredict_count[15:0] : saturating count of mispredicted updates

module branch_target_predictor #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef BP_PERF_CNT_EN
    input  logic        upd_mispredict,
    output logic [15:0] bp_update_count,
    output logic [15:0] bp_mispredict_count,
`endif
    input  logic [15:0] fetch_pc,
    output logic [15:0] predict_addr,
    output logic        predict_taken,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target
);

    localparam int unsigned TAG_W = 16 - 1 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [15:0]      target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t btb_q [ENTRIES];

    // PCs are word aligned, so bit 0 plays no part in index or tag.
    logic unused_pc_lsb;
    assign unused_pc_lsb = fetch_pc[0] ^ upd_pc[0];

    // Lookup: combinational read of the registered table, no bypass.
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    entry_t           fetch_entry;
    logic             fetch_hit;

    always_comb begin
        fetch_idx     = fetch_pc[IDX_W:1];
        fetch_tag     = fetch_pc[15:IDX_W+1];
        fetch_entry   = btb_q[fetch_idx];
        fetch_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
        predict_taken = fetch_hit && fetch_entry.ctr[1];
        predict_addr  = predict_taken ? fetch_entry.target : (fetch_pc + 16'h0002);
    end

    // Training: work out the replacement entry for the indexed slot.
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    entry_t           upd_cur;
    entry_t           upd_next;
    logic             upd_hit;
    logic             upd_write;

    always_comb begin
        upd_idx   = upd_pc[IDX_W:1];
        upd_tag   = upd_pc[15:IDX_W+1];
        upd_cur   = btb_q[upd_idx];
        upd_hit   = upd_cur.valid && (upd_cur.tag == upd_tag);
        upd_next  = upd_cur;
        upd_write = 1'b0;
        if (upd_valid) begin
            if (upd_hit) begin
                upd_write = 1'b1;
                if (upd_taken) begin
                    upd_next.ctr    = (upd_cur.ctr == 2'b11) ? 2'b11 : (upd_cur.ctr + 2'd1);
                    upd_next.target = upd_target;
                end else begin
                    upd_next.ctr    = (upd_cur.ctr == 2'b00) ? 2'b00 : (upd_cur.ctr - 2'd1);
                end
            end else if (upd_taken) begin
                // Allocate or replace; a new entry starts at weakly taken.
                upd_write       = 1'b1;
                upd_next.valid  = 1'b1;
                upd_next.tag    = upd_tag;
                upd_next.target = upd_target;
                upd_next.ctr    = 2'b10;
            end
        end
    end

    // Table storage; reset leaves every entry invalid and weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= 2'b01;
            end
        end else if (upd_write) begin
            btb_q[upd_idx] <= upd_next;
        end
    end

`ifdef BP_PERF_CNT_EN
    // Saturating update / mispredict event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_update_count     <= '0;
            bp_mispredict_count <= '0;
        end else if (upd_valid) begin
            if (bp_update_count != 16'hFFFF) begin
                bp_update_count <= bp_update_count + 16'd1;
            end
            if (upd_mispredict && (bp_mispredict_count != 16'hFFFF)) begin
                bp_mispredict_count <= bp_mispredict_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor
//   Self-checking bench for branch_target_predictor (ENTRIES = 8): a vector
//   table for the directed training sequence, hand-written sequences for
//   reset and event counters, then random traffic against a reference model.
//   Honours the BP_PERF_CNT_EN build macro.

module tb_branch_target_predictor;

    localparam int ENT = 8;

    logic        clk;
    logic        rst;
    logic [15:0] fetch_pc;
    logic [15:0] predict_addr;
    logic        predict_taken;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
`ifdef BP_PERF_CNT_EN
    logic        upd_mispredict;
    logic [15:0] bp_update_count;
    logic [15:0] bp_mispredict_count;
`endif

    int total;
    int bad;

    branch_target_predictor #(.ENTRIES(ENT)) dut (
        .clk                 (clk),
        .rst                 (rst),
`ifdef BP_PERF_CNT_EN
        .upd_mispredict      (upd_mispredict),
        .bp_update_count     (bp_update_count),
        .bp_mispredict_count (bp_mispredict_count),
`endif
        .fetch_pc            (fetch_pc),
        .predict_addr        (predict_addr),
        .predict_taken       (predict_taken),
        .upd_valid           (upd_valid),
        .upd_pc              (upd_pc),
        .upd_taken           (upd_taken),
        .upd_target          (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int m_valid [ENT];
    int m_tag   [ENT];
    int m_tgt   [ENT];
    int m_ctr   [ENT];
    int m_ucnt;
    int m_mcnt;

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_ucnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic void model_predict(input int pc, output int addr, output int tk);
        int idx;
        int tg;
        idx = (pc / 2) % ENT;
        tg  = pc / (2 * ENT);
        tk  = (m_valid[idx] != 0 && m_tag[idx] == tg && m_ctr[idx] >= 2) ? 1 : 0;
        addr = (tk != 0) ? m_tgt[idx] : ((pc + 2) % 65536);
    endfunction

    function automatic void model_update(input int pc, input int taken, input int tgt, input int mis);
        int idx;
        int tg;
        idx = (pc / 2) % ENT;
        tg  = pc / (2 * ENT);
        if (m_valid[idx] != 0 && m_tag[idx] == tg) begin
            if (taken != 0) begin
                m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                m_tgt[idx] = tgt;
            end else begin
                m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            end
        end else if (taken != 0) begin
            m_valid[idx] = 1;
            m_tag[idx]   = tg;
            m_tgt[idx]   = tgt;
            m_ctr[idx]   = 2;
        end
        if (m_ucnt < 65535) m_ucnt++;
        if (mis != 0 && m_mcnt < 65535) m_mcnt++;
    endfunction

    function automatic logic [15:0] rand_pc();
        logic [15:0] p;
        if ($urandom_range(0, 7) == 0) begin
            p = 16'($urandom);
        end else begin
            p = 16'h1000 | 16'($urandom_range(0, 3) << 4) | 16'($urandom_range(0, 15));
        end
        return p;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] fpc;
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic [15:0] eaddr;
        logic        etk;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic [15:0] fpc, input logic uv, input logic [15:0] upc,
                                input logic ut, input logic [15:0] utgt,
                                input logic [15:0] eaddr, input logic etk);
        vec_t v;
        v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.eaddr = eaddr; v.etk = etk;
        vq.push_back(v);
    endfunction

    task automatic idle_inputs();
        upd_valid  = 1'b0;
        upd_pc     = 16'h0000;
        upd_taken  = 1'b0;
        upd_target = 16'h0000;
`ifdef BP_PERF_CNT_EN
        upd_mispredict = 1'b0;
`endif
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int ea;
        int et;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        fetch_pc = 16'h1000;
        idle_inputs();
        model_reset();
        #1;
        check("reset_addr", int'(predict_addr), 'h1002);
        check("reset_taken", int'(predict_taken), 0);
`ifdef BP_PERF_CNT_EN
        check("reset_ucnt", int'(bp_update_count), 0);
        check("reset_mcnt", int'(bp_mispredict_count), 0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // fpc, uv, upc, ut, utgt, expected addr, expected taken (before the edge)
        add(16'h1000, 0, 16'h0000, 0, 16'h0000, 16'h1002, 0);
        add(16'h1000, 1, 16'h1000, 1, 16'h2000, 16'h1002, 0); // same-cycle alloc: no bypass
        add(16'h1000, 0, 16'h0000, 0, 16'h0000, 16'h2000, 1); // ctr 10
        add(16'h1000, 1, 16'h1000, 0, 16'h0000, 16'h2000, 1); // -> 01
        add(16'h1000, 1, 16'h1000, 1, 16'h2000, 16'h1002, 0); // -> 10
        add(16'h1000, 1, 16'h1000, 1, 16'h2000, 16'h2000, 1); // -> 11
        add(16'h1000, 1, 16'h1000, 1, 16'h2000, 16'h2000, 1); // hold 11
        add(16'h1000, 1, 16'h1000, 0, 16'h0000, 16'h2000, 1); // -> 10
        add(16'h1000, 1, 16'h1000, 0, 16'h0000, 16'h2000, 1); // -> 01
        add(16'h1000, 1, 16'h1000, 0, 16'h0000, 16'h1002, 0); // -> 00
        add(16'h1000, 1, 16'h1000, 0, 16'h0000, 16'h1002, 0); // hold 00
        add(16'h1000, 1, 16'h1000, 1, 16'h2000, 16'h1002, 0); // -> 01
        add(16'h1000, 1, 16'h1000, 1, 16'h2000, 16'h1002, 0); // -> 10
        add(16'h1000, 0, 16'h0000, 0, 16'h0000, 16'h2000, 1);
        add(16'h1010, 0, 16'h0000, 0, 16'h0000, 16'h1012, 0); // alias miss
        add(16'h1010, 1, 16'h1010, 1, 16'h3000, 16'h1012, 0); // replace
        add(16'h1010, 0, 16'h0000, 0, 16'h0000, 16'h3000, 1);
        add(16'h1000, 0, 16'h0000, 0, 16'h0000, 16'h1002, 0); // evicted
        add(16'hFFFE, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0); // wrap-around
        add(16'h1010, 1, 16'h1020, 0, 16'h5555, 16'h3000, 1); // miss NT: no change
        add(16'h1010, 0, 16'h0000, 0, 16'h0000, 16'h3000, 1);
        add(16'h1020, 0, 16'h0000, 0, 16'h0000, 16'h1022, 0);
        add(16'h1011, 1, 16'h1011, 1, 16'h4000, 16'h3000, 1); // bit 0 ignored, target rewrite
        add(16'h1010, 0, 16'h0000, 0, 16'h0000, 16'h4000, 1);

        foreach (vq[i]) begin
            fetch_pc   = vq[i].fpc;
            upd_valid  = vq[i].uv;
            upd_pc     = vq[i].upc;
            upd_taken  = vq[i].ut;
            upd_target = vq[i].utgt;
            #1;
            check($sformatf("vec%0d_addr", i), int'(predict_addr), int'(vq[i].eaddr));
            check($sformatf("vec%0d_taken", i), int'(predict_taken), int'(vq[i].etk));
            tick();
        end
        idle_inputs();

        // Asynchronous reset mid-cycle after training: effect before any edge.
        #2;
        rst = 1'b1;
        fetch_pc = 16'h1010;
        #1;
        check("async_rst_addr", int'(predict_addr), 'h1012);
        check("async_rst_taken", int'(predict_taken), 0);
        fetch_pc = 16'h1000;
        #1;
        check("async_rst_addr2", int'(predict_addr), 'h1002);

        // Update held across an edge with rst high is ignored; the first edge
        // with rst low writes it.
        upd_valid = 1'b1; upd_pc = 16'h1000; upd_taken = 1'b1; upd_target = 16'h5000;
        tick();
        rst = 1'b0;
        #1;
        check("rst_upd_ignored", int'(predict_taken), 0);
        tick();
        idle_inputs();
        #1;
        check("first_write_addr", int'(predict_addr), 'h5000);
        check("first_write_taken", int'(predict_taken), 1);

`ifdef BP_PERF_CNT_EN
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            upd_valid = 1'b1; upd_pc = 16'h2000; upd_taken = 1'b0;
            upd_mispredict = (i == 1 || i == 3) ? 1'b1 : 1'b0;
            tick();
        end
        idle_inputs();
        tick();
        check("perf_ucnt5", int'(bp_update_count), 5);
        check("perf_mcnt2", int'(bp_mispredict_count), 2);
        force dut.bp_update_count = 16'hFFFE;
        force dut.bp_mispredict_count = 16'hFFFE;
        #1;
        release dut.bp_update_count;
        release dut.bp_mispredict_count;
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1; upd_mispredict = 1'b1;
            tick();
        end
        idle_inputs();
        check("perf_ucnt_sat", int'(bp_update_count), 'hFFFF);
        check("perf_mcnt_sat", int'(bp_mispredict_count), 'hFFFF);
`endif

        // Random traffic against the reference model.
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            fetch_pc   = rand_pc();
            upd_valid  = ($urandom_range(0, 2) != 0);
            upd_pc     = (($urandom_range(0, 3) == 0) ? fetch_pc : rand_pc());
            upd_taken  = ($urandom_range(0, 99) < 60);
            upd_target = 16'($urandom);
`ifdef BP_PERF_CNT_EN
            upd_mispredict = $urandom_range(0, 1) != 0;
`endif
            #1;
            model_predict(int'(fetch_pc), ea, et);
            check("rand_addr", int'(predict_addr), ea);
            check("rand_taken", int'(predict_taken), et);
            @(posedge clk);
            if (upd_valid) begin
`ifdef BP_PERF_CNT_EN
                model_update(int'(upd_pc), int'(upd_taken), int'(upd_target), int'(upd_mispredict));
`else
                model_update(int'(upd_pc), int'(upd_taken), int'(upd_target), 0);
`endif
            end
            #1;
`ifdef BP_PERF_CNT_EN
            check("rand_ucnt", int'(bp_update_count), m_ucnt);
            check("rand_mcnt", int'(bp_mispredict_count), m_mcnt);
`endif
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
